// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: serial-to-word receiver with output FIFO.
// Serial bits qualified by bit_en are assembled into WIDTH-bit words.
// MSB_FIRST selects which end of the word the first received bit lands in.
// Each completed word updates last_word and is pushed into a DEPTH-entry
// FIFO. The FIFO is drained through a valid/ready handshake.
//
// Optional build macro: PARITY_EN.
// When it is defined, each frame carries a trailing even-parity bit.
// A frame with bad parity is dropped, and parity_err pulses for one cycle.
//
// Ports:
//   clk, rst_n  rising-edge clock and asynchronous active-low reset
//   bit_in      serial data bit, sampled when bit_en=1
//   bit_en      serial data qualifier
//   flush       synchronous; discards the partial word and clears overflow
//   last_word   most recently completed word
//   out_data    FIFO head; reads 0 when the FIFO is empty
//   out_valid   FIFO is not empty
//   out_ready   consumer accepts out_data
//   level       FIFO occupancy
//   overflow    sticky flag: a completed word was dropped because the FIFO was full
//   parity_err  one-cycle pulse on a bad-parity frame (always 0 without PARITY_EN)
module spi_rx_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         bit_in,
  input  logic                         bit_en,
  input  logic                         flush,
  output logic [WIDTH-1:0]             last_word,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         parity_err
);

`ifdef PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] sh_q, sh_d, shifted_c, word_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             frame_done_c, frame_good_c;
  logic             push_req_c, push_c, pop_c, full_c;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Next shift-register value, taking the configured bit order into account.
  always_comb begin
    if (MSB_FIRST != 0) shifted_c = {sh_q[WIDTH-2:0], bit_in};
    else                shifted_c = {bit_in, sh_q[WIDTH-1:1]};
  end

  // Deserialiser: bit counter, shift register and frame completion.
  always_comb begin
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    frame_done_c = 1'b0;
    frame_good_c = 1'b0;
    word_c       = shifted_c;
    if (flush) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (bit_en) begin
      if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
        cnt_d        = '0;
        frame_done_c = 1'b1;
`ifdef PARITY_EN
        // The final bit is the parity bit. It checks the word already held
        // in sh_q and is never shifted into it.
        sh_d         = '0;
        word_c       = sh_q;
        frame_good_c = ~((^sh_q) ^ bit_in);
`else
        sh_d         = shifted_c;
        frame_good_c = 1'b1;
`endif
      end else begin
        sh_d  = shifted_c;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // FIFO control. A pop on the same edge frees the slot for a push into a full FIFO.
  always_comb begin
    push_req_c = frame_done_c & frame_good_c;
    pop_c      = out_valid & out_ready;
    full_c     = (level_q == LVL_W'(DEPTH));
    push_c     = push_req_c & (~full_c | pop_c);
    last_d     = push_req_c ? word_c : last_q;
    wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (flush) ovf_d = 1'b0;
    else       ovf_d = ovf_q | (push_req_c & full_c & ~pop_c);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage. It needs no reset because out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= word_c;
  end

`ifdef PARITY_EN
  logic perr_q;

  // Registered one-cycle pulse for a bad-parity frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= frame_done_c & ~frame_good_c;
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign last_word = last_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed bench for spi_rx_fifo.
// Two instances run side by side: u_lsb (MSB_FIRST=0) and u_msb (MSB_FIRST=1).
// Both use WIDTH=8 and DEPTH=4.
module tb_spi_rx_fifo;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned LW = $clog2(D + 1);
`ifdef PARITY_EN
  localparam int unsigned FR = W + 1;
`else
  localparam int unsigned FR = W;
`endif

  logic clk = 1'b0;
  logic rst_n, bit_in, bit_en, flush, out_ready;
  logic [W-1:0]  l_last, l_data, m_last, m_data;
  logic [LW-1:0] l_level, m_level;
  logic          l_valid, m_valid, l_ovf, m_ovf, l_perr, m_perr;

  int n_cmp = 0;
  int n_err = 0;

  spi_rx_fifo #(.WIDTH(W), .MSB_FIRST(0), .DEPTH(D)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en), .flush(flush),
    .last_word(l_last), .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .level(l_level), .overflow(l_ovf), .parity_err(l_perr));

  spi_rx_fifo #(.WIDTH(W), .MSB_FIRST(1), .DEPTH(D)) u_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en), .flush(flush),
    .last_word(m_last), .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .level(m_level), .overflow(m_ovf), .parity_err(m_perr));

  always #5 clk = ~clk;

  typedef struct {
    logic       b, e, f, r;
    logic [7:0] exp_l, exp_m, exp_d;
    logic [2:0] exp_lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic b, e, f, r,
                              input logic [7:0] xl, xm, xd, input logic [2:0] xv);
    vec_t v;
    v.b = b; v.e = e; v.f = f; v.r = r;
    v.exp_l = xl; v.exp_m = xm; v.exp_d = xd; v.exp_lvl = xv;
    vecs.push_back(v);
  endfunction

  // seq[i] is the i-th received bit. Expectations switch to the new values on the completing edge.
  function automatic void add_frame(input logic [7:0] seq,
                                    input logic [7:0] pl, pm, pd, input logic [2:0] pv,
                                    input logic [7:0] nl, nm, nd, input logic [2:0] nv);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && FR == W) add(seq[i], 1'b1, 1'b0, 1'b0, nl, nm, nd, nv);
      else                   add(seq[i], 1'b1, 1'b0, 1'b0, pl, pm, pd, pv);
    end
    if (FR != W) add(^seq, 1'b1, 1'b0, 1'b0, nl, nm, nd, nv);
  endfunction

  // Sends one word LSB-first, with its even-parity bit when PARITY_EN is defined.
  // out_ready is raised only on the final edge when rdy_last=1.
  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 0; i < int'(FR); i++) begin
      bit_in    = (i < 8) ? w[i] : ^w;
      bit_en    = 1'b1;
      out_ready = (i == int'(FR) - 1) ? rdy_last : 1'b0;
      tick();
    end
    bit_en    = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_en = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Table contents.
    add_frame(8'b01010011, 8'h00, 8'h00, 8'h00, 3'd0, 8'h53, 8'hCA, 8'h53, 3'd1);
    add_frame(8'hFF,       8'h53, 8'hCA, 8'h53, 3'd1, 8'hFF, 8'hFF, 8'h53, 3'd2);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h53, 3'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h53, 3'd2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h53, 3'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h53, 3'd2);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h53, 3'd2);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h53, 3'd2);
    add_frame(8'hE5,       8'hFF, 8'hFF, 8'h53, 3'd2, 8'hE5, 8'hA7, 8'h53, 3'd3);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hE5, 8'hA7, 8'hFF, 3'd2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hE5, 8'hA7, 8'hE5, 3'd1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hE5, 8'hA7, 8'h00, 3'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hE5, 8'hA7, 8'h00, 3'd0);

    // Reset state.
    #12;
    chk("reset last_word", 32'(l_last), 32'h0);
    chk("reset level", 32'(l_level), 32'h0);
    chk("reset out_valid", 32'(l_valid), 32'h0);
    chk("reset out_data", 32'(l_data), 32'h0);
    chk("reset overflow", 32'(l_ovf), 32'h0);
    chk("reset parity_err", 32'(l_perr), 32'h0);
    rst_n = 1'b1;

    // Table-driven section.
    foreach (vecs[k]) begin
      bit_in = vecs[k].b; bit_en = vecs[k].e; flush = vecs[k].f; out_ready = vecs[k].r;
      tick();
      chk($sformatf("vec%0d lsb last_word", k), 32'(l_last), 32'(vecs[k].exp_l));
      chk($sformatf("vec%0d msb last_word", k), 32'(m_last), 32'(vecs[k].exp_m));
      chk($sformatf("vec%0d out_data", k), 32'(l_data), 32'(vecs[k].exp_d));
      chk($sformatf("vec%0d level", k), 32'(l_level), 32'(vecs[k].exp_lvl));
      chk($sformatf("vec%0d out_valid", k), 32'(l_valid), 32'(vecs[k].exp_lvl != 0));
    end
    bit_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    chk("table overflow", 32'(l_ovf), 32'h0);

    // Overflow: five frames are sent into a four-entry FIFO with no pops.
    for (int k = 1; k <= 5; k++) send_word(8'(k), 1'b0);
    chk("ovf level", 32'(l_level), 32'd4);
    chk("ovf flag", 32'(l_ovf), 32'h1);
    chk("ovf head", 32'(l_data), 32'h01);
    chk("ovf last_word", 32'(l_last), 32'h05);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d data", k), 32'(l_data), 32'(k));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("drain out_valid", 32'(l_valid), 32'h0);
    chk("drain overflow sticky", 32'(l_ovf), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush clears overflow", 32'(l_ovf), 32'h0);

    // Full FIFO: a push and a pop on the same edge.
    for (int k = 0; k < 4; k++) send_word(8'h11 + 8'(k), 1'b0);
    send_word(8'h15, 1'b1);
    chk("full push+pop level", 32'(l_level), 32'd4);
    chk("full push+pop overflow", 32'(l_ovf), 32'h0);
    chk("full push+pop head", 32'(l_data), 32'h12);
    chk("full push+pop last", 32'(l_last), 32'h15);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tail%0d data", k), 32'(l_data), 32'h12 + 32'(k));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("tail drained", 32'(l_level), 32'd0);

    // Asynchronous reset in the middle of a frame.
    send_word(8'h3C, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bit_in = 1'b1; bit_en = 1'b1;
      tick();
    end
    bit_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async rst last_word", 32'(l_last), 32'h0);
    chk("async rst level", 32'(l_level), 32'h0);
    chk("async rst out_valid", 32'(l_valid), 32'h0);
    chk("async rst out_data", 32'(l_data), 32'h0);
    #2;
    rst_n = 1'b1;
    send_word(8'h96, 1'b0);
    chk("post-rst last_word", 32'(l_last), 32'h96);
    chk("post-rst level", 32'(l_level), 32'd1);
    chk("post-rst head", 32'(l_data), 32'h96);
    chk("parity_err idle", 32'(l_perr), 32'h0);

`ifdef PARITY_EN
    // Bad parity drops the frame and pulses parity_err. Good parity accepts it.
    for (int i = 0; i < 9; i++) begin
      bit_in = (i < 8) ? ((8'h03 >> i) & 8'h01) != 0 : 1'b1;
      bit_en = 1'b1;
      tick();
    end
    bit_en = 1'b0;
    chk("bad parity pulse", 32'(l_perr), 32'h1);
    chk("bad parity level", 32'(l_level), 32'd1);
    chk("bad parity last", 32'(l_last), 32'h96);
    tick();
    chk("bad parity pulse end", 32'(l_perr), 32'h0);
    send_word(8'h03, 1'b0);
    chk("good parity level", 32'(l_level), 32'd2);
    chk("good parity last", 32'(l_last), 32'h03);
    chk("good parity no err", 32'(l_perr), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
